ram64: RTL and testbench

Sixty-four-word by 16-bit read/write memory, the first storage stage downstream of the elementary gate library. Load enables are routed through DMUX8WAY and read data is selected through MUX8WAY16. The block stores state on the clock edge and presents the addressed word combinationally. It will serve as the data/instruction memory building block for the CPU and the larger RAM512/RAM4K stages.

---
 rtl/ram64_pkg.sv | 33 +++
 rtl/ram64_ram8.sv | 61 ++++++
 rtl/ram64.sv | 36 +++
 tb/tb_ram64.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ram64_pkg.sv
// Shared word/depth constants and the gate-library select primitives (DMUX8WAY,
// MUX8WAY16) used by every RAM stage from RAM8 up through RAM4K.
package ram64_pkg;
  localparam int WORD_WIDTH      = 16;
  localparam int RAM8_DEPTH      = 8;
  localparam int RAM8_ADDR_BITS  = 3;
  localparam int RAM64_ADDR_BITS = 6;

  typedef logic [WORD_WIDTH-1:0] word_t;
  typedef word_t [RAM8_DEPTH-1:0] word8_t;

  // DMUX8WAY: route a single load onto the selected one of eight lines.
  // When load is low every line is low, whatever the select is.
  function automatic logic [RAM8_DEPTH-1:0] dmux8way(
    input logic                      load,
    input logic [RAM8_ADDR_BITS-1:0] sel
  );
    logic [RAM8_DEPTH-1:0] lines;
    lines = '0;
    for (int i = 0; i < RAM8_DEPTH; i++) begin
      lines[i] = load & (sel == i[RAM8_ADDR_BITS-1:0]);
    end
    return lines;
  endfunction

  // MUX8WAY16: pick one of eight words.
  function automatic word_t mux8way16(
    input word8_t                    words,
    input logic [RAM8_ADDR_BITS-1:0] sel
  );
    return words[sel];
  endfunction
endpackage

// File: rtl/ram64_ram8.sv
// Eight-word by 16-bit storage bank: per-word enabled registers with async clear,
// load demuxed by ADDRESS and read word selected combinationally by ADDRESS.
module ram8_reg16
  import ram64_pkg::*;
(
  input  logic  CLK,
  input  logic  RST_N,
  input  word_t IN,
  input  logic  LOAD,
  output word_t OUT
);
  word_t data_q;
  word_t data_d;

  always_comb begin
    data_d = data_q;
    if (LOAD) begin
      data_d = IN;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign OUT = data_q;
endmodule

module ram8
  import ram64_pkg::*;
(
  input  logic                      CLK,
  input  logic                      RST_N,
  input  logic [WORD_WIDTH-1:0]     IN,
  input  logic                      LOAD,
  input  logic [RAM8_ADDR_BITS-1:0] ADDRESS,
  output logic [WORD_WIDTH-1:0]     OUT
);
  logic [RAM8_DEPTH-1:0] word_load;
  word8_t                word_out;

  assign word_load = dmux8way(LOAD, ADDRESS);

  generate
    for (genvar gi = 0; gi < RAM8_DEPTH; gi++) begin : g_word
      ram8_reg16 u_reg (
        .CLK  (CLK),
        .RST_N(RST_N),
        .IN   (IN),
        .LOAD (word_load[gi]),
        .OUT  (word_out[gi])
      );
    end
  endgenerate

  assign OUT = mux8way16(word_out, ADDRESS);
endmodule

// File: rtl/ram64.sv
// Sixty-four-word by 16-bit RAM: eight RAM8 banks, load routed to the bank chosen
// by ADDRESS[5:3] and the same bits select which bank drives OUT.
module ram64
  import ram64_pkg::*;
(
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic [WORD_WIDTH-1:0]      IN,
  input  logic                       LOAD,
  input  logic [RAM64_ADDR_BITS-1:0] ADDRESS,
  output logic [WORD_WIDTH-1:0]      OUT
);
  logic [RAM8_ADDR_BITS-1:0] bank_sel;
  logic [RAM8_ADDR_BITS-1:0] word_sel;
  logic [RAM8_DEPTH-1:0]     bank_load;
  word8_t                    bank_out;

  assign bank_sel  = ADDRESS[RAM64_ADDR_BITS-1:RAM8_ADDR_BITS];
  assign word_sel  = ADDRESS[RAM8_ADDR_BITS-1:0];
  assign bank_load = dmux8way(LOAD, bank_sel);

  generate
    for (genvar gi = 0; gi < RAM8_DEPTH; gi++) begin : g_bank
      ram8 u_bank (
        .CLK    (CLK),
        .RST_N  (RST_N),
        .IN     (IN),
        .LOAD   (bank_load[gi]),
        .ADDRESS(word_sel),
        .OUT    (bank_out[gi])
      );
    end
  endgenerate

  assign OUT = mux8way16(bank_out, bank_sel);
endmodule

// File: tb/tb_ram64.sv
// Directed bench for ram64: a scoreboard queue of expected OUT values is filled
// as stimulus is applied and drained by immediate-assertion checks.
module tb_ram64;
  logic        CLK;
  logic        RST_N;
  logic [15:0] IN;
  logic        LOAD;
  logic [5:0]  ADDRESS;
  logic [15:0] OUT;

  ram64 dut (
    .CLK    (CLK),
    .RST_N  (RST_N),
    .IN     (IN),
    .LOAD   (LOAD),
    .ADDRESS(ADDRESS),
    .OUT    (OUT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [15:0] val;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] model[64];
  int          checks   = 0;
  int          failures = 0;

  task automatic push_exp(input string tag, input logic [15:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic pop_check();
    exp_t        e;
    logic [15:0] obs;
    obs = OUT;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%h expected=<none>", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val)
      else begin
        failures++;
        $error("FAIL %s addr=%0d observed=%h expected=%h", e.tag, ADDRESS, obs, e.val);
      end
    end
  endtask

  task automatic do_write(input logic [5:0] a, input logic [15:0] d);
    @(negedge CLK);
    ADDRESS = a;
    IN      = d;
    LOAD    = 1'b1;
    @(posedge CLK);
    #1;
    LOAD     = 1'b0;
    model[a] = d;
  endtask

  task automatic read_check(input logic [5:0] a, input string tag);
    @(negedge CLK);
    ADDRESS = a;
    LOAD    = 1'b0;
    push_exp(tag, model[a]);
    #1;
    pop_check();
  endtask

  initial begin
    RST_N   = 1'b0;
    LOAD    = 1'b0;
    IN      = 16'h0;
    ADDRESS = 6'd0;
    for (int i = 0; i < 64; i++) model[i] = 16'h0000;

    // Reset held: writes ignored, OUT zero at any address.
    @(negedge CLK);
    ADDRESS = 6'd37;
    IN      = 16'hDEAD;
    LOAD    = 1'b1;
    push_exp("in_reset", 16'h0000);
    #1;
    pop_check();
    @(negedge CLK);
    LOAD = 1'b0;
    #1;
    RST_N = 1'b1;

    for (int a = 0; a < 64; a++) read_check(6'(a), "reset_scan");

    // Fill and readback.
    for (int a = 0; a < 64; a++) do_write(6'(a), 16'hA500 + 16'(a));
    for (int a = 0; a < 64; a++) read_check(6'(a), "fill_readback");

    // Read-during-write, same address.
    do_write(6'd12, 16'h1234);
    @(negedge CLK);
    ADDRESS = 6'd12;
    IN      = 16'hBEEF;
    LOAD    = 1'b1;
    push_exp("rdw_before", 16'h1234);
    #1;
    pop_check();
    @(posedge CLK);
    #1;
    push_exp("rdw_after", 16'hBEEF);
    pop_check();
    LOAD      = 1'b0;
    model[12] = 16'hBEEF;
    read_check(6'd13, "rdw_neighbor");

    // Read-during-write, different address: OUT tracks the read address only.
    @(negedge CLK);
    ADDRESS = 6'd5;
    IN      = 16'h5555;
    LOAD    = 1'b1;
    @(posedge CLK);
    #1;
    LOAD     = 1'b0;
    model[5] = 16'h5555;
    ADDRESS  = 6'd6;
    push_exp("rdw_other_addr", model[6]);
    #1;
    pop_check();

    // Back-to-back writes to one address.
    @(negedge CLK);
    ADDRESS = 6'd20;
    IN      = 16'h1111;
    LOAD    = 1'b1;
    @(posedge CLK);
    #1;
    push_exp("b2b_first", 16'h1111);
    pop_check();
    IN = 16'h2222;
    @(posedge CLK);
    #1;
    push_exp("b2b_second", 16'h2222);
    pop_check();
    LOAD      = 1'b0;
    model[20] = 16'h2222;

    // LOAD=0 hold with wiggling IN.
    for (int c = 0; c < 10; c++) begin
      @(negedge CLK);
      ADDRESS = 6'd40;
      IN      = 16'($urandom);
      LOAD    = 1'b0;
      @(posedge CLK);
      #1;
      push_exp("load0_hold", model[40]);
      pop_check();
    end

    // Unknown address with LOAD=0 must not disturb storage.
    @(negedge CLK);
    ADDRESS = 6'bxxxxxx;
    IN      = 16'hFACE;
    LOAD    = 1'b0;
    @(posedge CLK);
    @(posedge CLK);
    #1;
    read_check(6'd0, "x_addr_hold");
    read_check(6'd7, "x_addr_hold");
    read_check(6'd8, "x_addr_hold");
    read_check(6'd55, "x_addr_hold");
    read_check(6'd63, "x_addr_hold");

    // Mid-operation reset: short low pulse between edges.
    @(negedge CLK);
    ADDRESS = 6'd33;
    push_exp("pre_reset", model[33]);
    #1;
    pop_check();
    @(posedge CLK);
    #1;
    RST_N = 1'b0;
    #1;
    push_exp("reset_immediate", 16'h0000);
    pop_check();
    #1;
    RST_N = 1'b1;
    for (int i = 0; i < 64; i++) model[i] = 16'h0000;
    for (int a = 0; a < 64; a++) read_check(6'(a), "post_reset_scan");

    do_write(6'd63, 16'hFFFF);
    read_check(6'd63, "post_reset_write");
    read_check(6'd62, "post_reset_neighbor");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
